vector_output_drain: RTL and testbench

- Sits directly downstream of the CPU output port (out, outFlag).
- Captures each 96-bit vector result in the cycle outFlag is high and buffers it in a small FIFO.
- Drains each stored vector one 16-bit lane at a time over a valid/ready stream, for a narrow sink such as a UART or a debug capture bridge.
- Keeps the CPU from stalling or losing results while the sink is slow.

---
 rtl/vector_output_drain.sv | 172 +++++++++++++++++
 tb/tb_vector_output_drain.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_output_drain.sv
// vector_output_drain
//
// Buffers whole vector results from the CPU output port in a small FIFO.
// Each buffered vector is then sent to a narrow sink one lane at a time
// over a valid/ready stream. A slow sink therefore never stalls the CPU.
// If the FIFO cannot take a vector, that vector is dropped and a sticky
// overflow flag is raised.
//
// Ports:
//   clock      rising-edge clock shared with the CPU
//   reset      synchronous, active-low reset (0 = reset)
//   outFlag    CPU output strobe; out is valid this cycle
//   out        CPU output vector; lane i = out[i*DATA_WIDTH +: DATA_WIDTH]
//   laneData   lane currently presented to the sink
//   laneIndex  index of the lane on laneData
//   laneValid  laneData/laneIndex valid
//   laneReady  sink accepts the presented lane
//   lastLane   presented lane is the final lane of its vector
//   fifoCount  number of whole vectors buffered, 0..FIFO_DEPTH
//   overflow   sticky: at least one vector was dropped since reset
//   busy       FIFO not empty or a vector is still being sent
module vector_output_drain #(
    parameter int DATA_WIDTH  = 16,
    parameter int VECTOR_SIZE = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int PTR_WIDTH   = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              outFlag,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] out,
    output logic [DATA_WIDTH-1:0]             laneData,
    output logic [2:0]                        laneIndex,
    output logic                              laneValid,
    input  logic                              laneReady,
    output logic                              lastLane,
    output logic [PTR_WIDTH:0]                fifoCount,
    output logic                              overflow,
    output logic                              busy
);

    localparam int VEC_W = DATA_WIDTH * VECTOR_SIZE;
    localparam logic [2:0]         LAST_IDX = 3'(VECTOR_SIZE - 1);
    localparam logic [PTR_WIDTH:0] DEPTH_C  = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Vector storage. It has no reset: the pointers and the count define
    // which entries are meaningful.
    logic [VEC_W-1:0]     mem_q [FIFO_DEPTH];

    state_t               state_q;
    logic [PTR_WIDTH-1:0] wr_ptr_q;
    logic [PTR_WIDTH-1:0] rd_ptr_q;
    logic [PTR_WIDTH:0]   count_q;
    logic [PTR_WIDTH:0]   count_d;
    logic [VEC_W-1:0]     holding_q;
    logic [DATA_WIDTH-1:0] lane_data_q;
    logic [2:0]           lane_index_q;
    logic                 lane_valid_q;
    logic                 last_lane_q;
    logic                 overflow_q;

    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [VEC_W-1:0]     head;
    logic [2:0]           next_index;

    // Lane views of the FIFO head and of the holding register.
    logic [DATA_WIDTH-1:0] head_lane [VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] hold_lane [VECTOR_SIZE];

    assign head = mem_q[rd_ptr_q];

    generate
        for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lanes
            assign head_lane[gi] = head[gi*DATA_WIDTH +: DATA_WIDTH];
            assign hold_lane[gi] = holding_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A pop happens only from IDLE, and it uses the count from before this
    // edge. A vector pushed into an empty FIFO is therefore never popped on
    // the same edge. A pop frees a slot, so a full FIFO can still accept a
    // push on the edge where it pops.
    assign pop        = (state_q == IDLE) && (count_q != '0);
    assign push       = outFlag && ((count_q != DEPTH_C) || pop);
    assign drop       = outFlag && !push;
    assign next_index = lane_index_q + 3'd1;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= out;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            holding_q    <= '0;
            lane_data_q  <= '0;
            lane_index_q <= '0;
            lane_valid_q <= 1'b0;
            last_lane_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        holding_q    <= head;
                        rd_ptr_q     <= rd_ptr_q + 1'b1;
                        lane_index_q <= '0;
                        lane_data_q  <= head_lane[0];
                        lane_valid_q <= 1'b1;
                        last_lane_q  <= (VECTOR_SIZE == 1);
                        state_q      <= SEND;
                    end
                end
                SEND: begin
                    // The holding register is not written in SEND. With
                    // laneReady low, every lane output keeps its value.
                    if (lane_valid_q && laneReady) begin
                        if (last_lane_q) begin
                            lane_valid_q <= 1'b0;
                            last_lane_q  <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            lane_index_q <= next_index;
                            lane_data_q  <= hold_lane[next_index];
                            last_lane_q  <= (next_index == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign laneData  = lane_data_q;
    assign laneIndex = lane_index_q;
    assign laneValid = lane_valid_q;
    assign lastLane  = last_lane_q;
    assign fifoCount = count_q;
    assign overflow  = overflow_q;
    assign busy      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_vector_output_drain.sv
module tb_vector_output_drain;

    logic        clock;
    logic        reset;
    logic        outFlag;
    logic [95:0] out;
    logic [15:0] laneData;
    logic [2:0]  laneIndex;
    logic        laneValid;
    logic        laneReady;
    logic        lastLane;
    logic [2:0]  fifoCount;
    logic        overflow;
    logic        busy;

    vector_output_drain dut (
        .clock     (clock),
        .reset     (reset),
        .outFlag   (outFlag),
        .out       (out),
        .laneData  (laneData),
        .laneIndex (laneIndex),
        .laneValid (laneValid),
        .laneReady (laneReady),
        .lastLane  (lastLane),
        .fifoCount (fifoCount),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cycle = 0;

    // Reference model: a queue of whole vectors, the vector being sent,
    // and the lane position inside it.
    logic [95:0] m_q[$];
    logic [95:0] m_cur;
    int          m_lane;
    bit          m_present;
    bit          m_ovf;

    // Lanes accepted by the sink (valid and ready together at an edge).
    logic [15:0] acc_q[$];

    typedef struct {
        logic        rst_n;
        logic        flag;
        logic [95:0] vec;
        logic        ready;
        logic        e_valid;
        logic [15:0] e_data;
        logic [2:0]  e_idx;
        logic        e_last;
        logic [2:0]  e_cnt;
        logic        e_busy;
        logic        e_ovf;
        logic        chk_di;
    } row_t;

    function automatic logic [95:0] mk(input int base);
        logic [95:0] v;
        for (int i = 0; i < 6; i++) v[i*16 +: 16] = 16'(base + i);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic [95:0] v, input logic rd);
        bit do_pop;
        bit accept;
        if (!r) begin
            m_q.delete();
            m_present = 0;
            m_lane    = 0;
            m_ovf     = 0;
        end else begin
            do_pop = !m_present && (m_q.size() > 0);
            accept = f && ((m_q.size() < 4) || do_pop);
            if (m_present && rd) begin
                if (m_lane == 5) m_present = 0;
                else m_lane++;
            end
            if (do_pop) begin
                m_cur     = m_q.pop_front();
                m_present = 1;
                m_lane    = 0;
            end
            if (accept) m_q.push_back(v);
            else if (f) m_ovf = 1;
        end
    endtask

    task automatic compare_model();
        chk("m_valid", 32'(laneValid), 32'(m_present));
        chk("m_count", 32'(fifoCount), 32'(m_q.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_busy", 32'(busy), 32'(m_present || (m_q.size() != 0)));
        chk("m_last", 32'(lastLane), 32'(m_present && (m_lane == 5)));
        if (m_present) begin
            chk("m_data", 32'(laneData), 32'(m_cur[m_lane*16 +: 16]));
            chk("m_index", 32'(laneIndex), 32'(m_lane));
        end
    endtask

    // Drive one cycle of inputs and clock the DUT and the model. Then
    // compare outputs at the falling edge.
    task automatic step(input logic r, input logic f, input logic [95:0] v, input logic rd);
        reset     = r;
        outFlag   = f;
        out       = v;
        laneReady = rd;
        if (r && laneValid === 1'b1 && rd) acc_q.push_back(laneData);
        @(posedge clock);
        cycle++;
        model_update(r, f, v, rd);
        @(negedge clock);
        compare_model();
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, '0, 1'b0);
        acc_q.delete();
    endtask

    task automatic check_stream(input string name, input int first_base, input int n_vectors);
        chk({name, "_len"}, 32'(acc_q.size()), 32'(n_vectors * 6));
        for (int k = 0; k < n_vectors * 6 && k < acc_q.size(); k++)
            chk(name, 32'(acc_q[k]), 32'(first_base + (k / 6) * 16'h1000 + (k % 6)));
    endtask

    row_t tbl[9];

    initial begin
        reset = 1'b0; outFlag = 1'b0; out = '0; laneReady = 1'b0;
        @(negedge clock);

        // Single vector, lanes 1..6, sink always ready.
        tbl[0] = '{1'b0, 1'b0, 96'd0,  1'b0, 1'b0, 16'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, mk(1),  1'b1, 1'b0, 16'd0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd2, 3'd1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd3, 3'd2, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd4, 3'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd5, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b1, 16'd6, 3'd5, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 96'd0,  1'b1, 1'b0, 16'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].rst_n, tbl[i].flag, tbl[i].vec, tbl[i].ready);
            chk("t_valid", 32'(laneValid), 32'(tbl[i].e_valid));
            chk("t_last", 32'(lastLane), 32'(tbl[i].e_last));
            chk("t_count", 32'(fifoCount), 32'(tbl[i].e_cnt));
            chk("t_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("t_overflow", 32'(overflow), 32'(tbl[i].e_ovf));
            if (tbl[i].chk_di) begin
                chk("t_data", 32'(laneData), 32'(tbl[i].e_data));
                chk("t_index", 32'(laneIndex), 32'(tbl[i].e_idx));
            end
        end

        // Backpressure: ready pattern 1,0,0,1 repeating.
        do_reset();
        step(1'b1, 1'b1, mk(1), 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
        check_stream("bp_lane", 1, 1);

        // Overflow: A..F pushed while the sink is stalled, F is dropped.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, mk(16'hA000 + i * 16'h1000), 1'b0);
        chk("ovf_count", 32'(fifoCount), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        acc_q.delete();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b1);
        check_stream("ovf_lane", 16'hA000, 5);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop on the same edge while the FIFO is full.
        begin
            bit found;
            do_reset();
            for (int i = 0; i < 5; i++) step(1'b1, 1'b1, mk(16'h1000 + i * 16'h1000), 1'b0);
            found = 0;
            for (int i = 0; i < 10 && !found; i++) begin
                step(1'b1, 1'b0, '0, 1'b1);
                if (laneValid && lastLane) found = 1;
            end
            chk("pp_reach_last", 32'(found), 32'd1);
            step(1'b1, 1'b0, '0, 1'b1);
            chk("pp_idle_valid", 32'(laneValid), 32'd0);
            chk("pp_idle_count", 32'(fifoCount), 32'd4);
            step(1'b1, 1'b1, mk(16'h6000), 1'b0);
            chk("pp_count", 32'(fifoCount), 32'd4);
            chk("pp_overflow", 32'(overflow), 32'd0);
            acc_q.delete();
            for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0, 1'b1);
            check_stream("pp_lane", 16'h2000, 5);
        end

        // Reset while lane 3 is presented and 2 vectors are buffered.
        begin
            bit found;
            do_reset();
            for (int i = 0; i < 3; i++) step(1'b1, 1'b1, mk(16'h1000 + i * 16'h1000), 1'b1);
            found = (laneValid && laneIndex == 3'd3);
            for (int i = 0; i < 10 && !found; i++) begin
                step(1'b1, 1'b0, '0, 1'b1);
                if (laneValid && laneIndex == 3'd3) found = 1;
            end
            chk("rst_reach_lane3", 32'(found), 32'd1);
            chk("rst_pre_count", 32'(fifoCount), 32'd2);
            do_reset();
            chk("rst_valid", 32'(laneValid), 32'd0);
            chk("rst_count", 32'(fifoCount), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            step(1'b1, 1'b1, mk(16'h7000), 1'b1);
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b1);
            check_stream("rst_lane", 16'h7000, 1);
        end

        // Back-to-back: three vectors, exactly one bubble between them.
        begin
            int n_valid, n_gap, first, last_v;
            bit vhist[25];
            do_reset();
            for (int i = 0; i < 25; i++) begin
                if (i < 3) step(1'b1, 1'b1, mk(16'h1000 + i * 16'h1000), 1'b1);
                else step(1'b1, 1'b0, '0, 1'b1);
                vhist[i] = laneValid;
            end
            n_valid = 0; n_gap = 0; first = -1; last_v = -1;
            for (int i = 0; i < 25; i++) if (vhist[i]) begin
                n_valid++;
                if (first < 0) first = i;
                last_v = i;
            end
            for (int i = 0; i < 25; i++) if (first >= 0 && i > first && i < last_v && !vhist[i]) n_gap++;
            chk("b2b_valid_cycles", 32'(n_valid), 32'd18);
            chk("b2b_bubbles", 32'(n_gap), 32'd2);
            chk("b2b_first", 32'(first), 32'd1);
            check_stream("b2b_lane", 16'h1000, 3);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic r, f, rd;
            r  = ($urandom_range(0, 149) != 0);
            f  = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
            step(r, f, {$urandom, $urandom, $urandom}, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
